arb5_rr_onehot: RTL and testbench
=================================

ARB5_RR_ONEHOT -- requirements
Module: arb5_rr_onehot

Interface
- REQ-001: Parameter N, default 5, number of requesters; fixed at 5 in this revision.
- REQ-002: Parameter DW, default 8, data width per requester.
- REQ-003: clk  input  1  single clock; all state updates on rising edge.
- REQ-004: rst  input  1  reset, synchronous, active-high.
- REQ-005: req  input  N  per-requester request; held high until the matching ack.
- REQ-006: data_in  input  N*DW  requester data, requester i in bits [DW*i+DW-1 : DW*i]; must stay stable while req[i] is high.
- REQ-007: ack  output  N  one-hot pulse marking the requester whose data is transferred this cycle.
- REQ-008: sel  output  N  registered one-hot grant, driven straight to the downstream 5x1 one-hot mux select.
- REQ-009: out_valid  output  1  sel is non-zero and the selected data is offered downstream.
- REQ-010: out_ready  input  1  downstream accepts the offered data this cycle.
- REQ-011: lock  input  1  present only with ARB_LOCK_EN defined (see Configuration).

Function
- REQ-012: The FSM SHALL have two states: IDLE (sel = 0, out_valid = 0) and GRANT (sel one-hot, out_valid = 1).
- REQ-013: In IDLE, if req != 0, the next state SHALL be GRANT, with sel set to the round-robin winner; req-to-sel latency is 1 cycle.
- REQ-014: The round-robin winner SHALL be the first set bit of req, scanning upward from priority pointer ptr (0..4) and wrapping 4 -> 0.
- REQ-015: In GRANT, sel and out_valid SHALL hold unchanged while out_ready = 0, whatever req does.
- REQ-016: A transfer occurs when out_valid = 1 and out_ready = 1; in that cycle ack = sel (combinational), otherwise ack = 0.
- REQ-017: On a transfer, ptr SHALL become (granted index + 1) mod 5; index 4 wraps to 0.
- REQ-018: On a transfer, the block SHALL re-arbitrate in the same cycle using the updated ptr and req with the acked bit masked off.
  - If any request remains: stay in GRANT, with the new sel in the next cycle (back-to-back, no bubble).
  - Otherwise: go to IDLE.
- REQ-019: A requester that re-asserts req in the cycle after its ack SHALL be treated as a new request at lowest priority.
- REQ-020: sel SHALL never have more than one bit set; sel = 0 exactly when out_valid = 0.
- REQ-021: A req[i] that drops while not granted SHALL be ignored; a req drop while granted is a protocol violation, and the grant is held until transfer anyway.
- REQ-022: The block SHALL NOT register data_in; data flows through the downstream mux, so the data path is combinational from data_in.

Reset
- REQ-023: While rst = 1 at a clock edge, the block SHALL load state = IDLE, sel = 0, out_valid = 0, ptr = 0.
- REQ-024: ack SHALL be 0 during any cycle in which rst = 1.
- REQ-025: Reset asserted mid-GRANT SHALL abandon the pending transfer with no ack; arbitration restarts from ptr = 0 in the first cycle after rst falls.

Configuration
- REQ-026: Macro ARB_LOCK_EN defined: the lock input exists, and a transfer with lock = 1 SHALL leave ptr unchanged and keep the same requester granted if its req is still high (burst).
- REQ-027: Macro ARB_LOCK_EN undefined: no lock port, and ptr always advances per REQ-017.

Structure
- REQ-028: A shared package/header SHALL hold N, DW, the state encodings ST_IDLE/ST_GRANT, and the one-hot width N.
- REQ-029: The wrap-around priority search SHALL be a combinational sub-module rr_pick5 (inputs req, ptr; outputs one-hot win and any); it is instantiated once.
- REQ-030: The top level SHALL contain only the FSM, the ptr register, sel/out_valid registers and ack logic; it must not duplicate the mux.

Verification
- REQ-031: Reset, then req = 5'b00100, out_ready = 1 -> next cycle sel = 5'b00100, out_valid = 1, ack = 5'b00100; then ptr = 3, state IDLE.
- REQ-032: req = 5'b11111 held, out_ready = 1 constant -> sel sequence 00001, 00010, 00100, 01000, 10000, 00001, with no idle cycle.
- REQ-033: Grant 00010 active with out_ready = 0 for 4 cycles while req changes to 11101 -> sel stays 00010 and ack = 0; on out_ready = 1, ack = 00010 and next sel = 00100.
- REQ-034: ptr = 4, req = 5'b00011 -> sel = 00001 (wrap-around); after transfer, next sel = 00010.
- REQ-035: rst = 1 during GRANT with sel = 01000 -> next cycle sel = 0, out_valid = 0, no ack; after release, req = 11111 gives sel = 00001.
- REQ-036: With ARB_LOCK_EN, req = 00011, lock = 1 for 3 transfers -> sel stays 00001 for all 3 acks; lock = 0 on the 4th transfer -> next sel = 00010.

Source files
------------

// File: rtl/arb5_rr_onehot_pkg.sv
// Shared constants, state encoding and index helpers for the 5-way round-robin arbiter.
// Optional burst locking is enabled with the ARB_LOCK_EN macro.
package arb5_rr_onehot_pkg;

    localparam int N        = 5;
    localparam int DW       = 8;
    localparam int ONEHOT_W = N;
    localparam int PTR_W    = 3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [ONEHOT_W-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < ONEHOT_W; i++) begin
            if (oh[i]) begin
                idx = idx | PTR_W'(i);
            end
        end
        return idx;
    endfunction

    // Priority pointer advance with wrap from the last requester back to 0.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(ONEHOT_W - 1)) ? '0 : p + PTR_W'(1);
    endfunction

endpackage

// File: rtl/arb5_rr_onehot_pick.sv
// Combinational wrap-around priority search: first set bit of req at or above ptr,
// wrapping 4 -> 0. Result is one-hot in win; any flags a non-empty request vector.
module rr_pick5
    import arb5_rr_onehot_pkg::*;
(
    input  logic [ONEHOT_W-1:0] req,
    input  logic [PTR_W-1:0]    ptr,
    output logic [ONEHOT_W-1:0] win,
    output logic                any
);

    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < ONEHOT_W; k++) begin
            idx = PTR_W'((int'(ptr) + k) % ONEHOT_W);
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/arb5_rr_onehot.sv
// Round-robin arbiter with registered one-hot select for a downstream 5x1 mux.
// ARB_LOCK_EN adds a lock input that keeps the current requester granted across transfers.
module arb5_rr_onehot
    import arb5_rr_onehot_pkg::*;
#(
    parameter int N  = arb5_rr_onehot_pkg::N,
    parameter int DW = arb5_rr_onehot_pkg::DW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*DW-1:0] data_in,
    output logic [N-1:0]    ack,
    output logic [N-1:0]    sel,
    output logic            out_valid,
    input  logic            out_ready
`ifdef ARB_LOCK_EN
    ,
    input  logic            lock
`endif
);

    // Handshake: a transfer happens in any cycle with out_valid && out_ready;
    // sel/out_valid are held stable until then, and ack mirrors sel in that cycle only.

    state_e           state_q, state_d;
    logic [N-1:0]     sel_q, sel_d;
    logic             valid_q, valid_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;

    logic             xfer;
    logic             lock_i;
    logic [PTR_W-1:0] gnt_idx;
    logic [N-1:0]     pick_req;
    logic [PTR_W-1:0] pick_ptr;
    logic [N-1:0]     pick_win;
    logic             pick_any;
    logic             unused_data;

`ifdef ARB_LOCK_EN
    assign lock_i = lock;
`else
    assign lock_i = 1'b0;
`endif

    // Data goes straight from data_in through the downstream mux driven by sel.
    assign unused_data = ^data_in;

    assign xfer    = valid_q & out_ready;
    assign gnt_idx = onehot_to_idx(sel_q);

    // Re-arbitration inputs: idle uses raw req; a transfer masks the acked bit and
    // searches from the advanced pointer, or from the granted index when locked.
    always_comb begin
        ptr_d    = ptr_q;
        pick_req = req;
        pick_ptr = ptr_q;
        if (state_q == ST_GRANT && xfer) begin
            if (lock_i) begin
                pick_ptr = gnt_idx;
            end else begin
                ptr_d    = ptr_inc(gnt_idx);
                pick_ptr = ptr_d;
                pick_req = req & ~sel_q;
            end
        end
    end

    rr_pick5 u_pick (
        .req (pick_req),
        .ptr (pick_ptr),
        .win (pick_win),
        .any (pick_any)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_GRANT;
                    sel_d   = pick_win;
                    valid_d = 1'b1;
                end
            end
            ST_GRANT: begin
                if (xfer) begin
                    if (pick_any) begin
                        sel_d = pick_win;
                    end else begin
                        state_d = ST_IDLE;
                        sel_d   = '0;
                        valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign ack       = (xfer && !rst) ? sel_q : '0;
    assign sel       = sel_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_arb5_rr_onehot.sv
// Self-checking bench for arb5_rr_onehot: directed scenarios plus a randomized run
// against a cycle-level round-robin model; acks are checked from an expected queue.
module tb_arb5_rr_onehot;
  import arb5_rr_onehot_pkg::*;

  localparam int NR  = 5;
  localparam int DWB = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*DWB-1:0] data_in;
  logic [NR-1:0]     ack;
  logic [NR-1:0]     sel;
  logic              out_valid;
  logic              out_ready;
`ifdef ARB_LOCK_EN
  logic              lock;
`endif

  int            n_vec = 0;
  int            n_err = 0;
  logic [NR-1:0] exp_q[$];
  logic [NR-1:0] mon_exp;
  bit            mon_en = 1'b0;

  arb5_rr_onehot #(.N(NR), .DW(DWB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data_in   (data_in),
    .ack       (ack),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef ARB_LOCK_EN
    ,
    .lock      (lock)
`endif
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1, "watchdog expired");
  end

  // ack scoreboard
  always @(negedge clk) begin
    if (mon_en && ack != '0) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL ack_unexpected: got %b, required no ack", ack);
      end else begin
        mon_exp = exp_q.pop_front();
        if (ack !== mon_exp) begin
          n_err++;
          $display("FAIL ack_order: got %b, required %b", ack, mon_exp);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    out_ready = 1'b0;
`ifdef ARB_LOCK_EN
    lock = 1'b0;
`endif
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic check_drained(input string name);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: %0d acks still expected, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  function automatic logic [NR-1:0] rr_model(input logic [NR-1:0] r, input int p);
    for (int k = 0; k < NR; k++) begin
      int i;
      i = (p + k) % NR;
      if (r[i]) return NR'(1) << i;
    end
    return '0;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    req = '1;
    out_ready = 1'b1;
    data_in = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
`ifdef ARB_LOCK_EN
    lock = 1'b0;
`endif
    next_cycle();
    mon_en = 1'b1;
    next_cycle();
    @(negedge clk);
    n_vec++; if (sel !== 5'b00000) begin n_err++; $display("FAIL reset_sel: got %b, required 00000", sel); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b, required 0", out_valid); end
    n_vec++; if (ack !== 5'b00000) begin n_err++; $display("FAIL reset_ack: got %b, required 00000", ack); end
    n_vec++; if (dut.ptr_q !== 3'd0) begin n_err++; $display("FAIL reset_ptr: got %0d, required 0", dut.ptr_q); end
    n_vec++; if (dut.state_q !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d, required IDLE", dut.state_q); end
    rst = 1'b0;
    req = '0;
    out_ready = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req = 5'b00100;
    out_ready = 1'b1;
    exp_q.push_back(5'b00100);
    @(negedge clk);
    n_vec++; if (sel !== 5'b00000) begin n_err++; $display("FAIL single_latency: got %b, required 00000", sel); end
    next_cycle();
    @(negedge clk);
    n_vec++; if (sel !== 5'b00100) begin n_err++; $display("FAIL single_sel: got %b, required 00100", sel); end
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b, required 1", out_valid); end
    n_vec++; if (ack !== 5'b00100) begin n_err++; $display("FAIL single_ack: got %b, required 00100", ack); end
    next_cycle();
    req = '0;
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_idle_valid: got %b, required 0", out_valid); end
    n_vec++; if (dut.ptr_q !== 3'd3) begin n_err++; $display("FAIL single_ptr: got %0d, required 3", dut.ptr_q); end
    n_vec++; if (dut.state_q !== ST_IDLE) begin n_err++; $display("FAIL single_state: got %0d, required IDLE", dut.state_q); end
    check_drained("single");
  endtask

  task automatic test_back_to_back();
    logic [NR-1:0] seq[6];
    seq = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
    do_reset();
    req = 5'b11111;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) exp_q.push_back(seq[k]);
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      @(negedge clk);
      n_vec++; if (sel !== seq[k]) begin n_err++; $display("FAIL b2b_sel%0d: got %b, required %b", k, sel, seq[k]); end
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid%0d: got %b, required 1", k, out_valid); end
    end
    next_cycle();
    out_ready = 1'b0;
    req = '0;
    @(negedge clk);
    n_vec++; if (sel !== 5'b00010) begin n_err++; $display("FAIL b2b_tail: got %b, required 00010", sel); end
    check_drained("b2b");
  endtask

  task automatic test_hold();
    do_reset();
    req = 5'b00010;
    out_ready = 1'b0;
    next_cycle();
    req = 5'b11101;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_vec++; if (sel !== 5'b00010) begin n_err++; $display("FAIL hold_sel%0d: got %b, required 00010", k, sel); end
      n_vec++; if (ack !== 5'b00000) begin n_err++; $display("FAIL hold_ack%0d: got %b, required 00000", k, ack); end
      next_cycle();
    end
    out_ready = 1'b1;
    exp_q.push_back(5'b00010);
    @(negedge clk);
    n_vec++; if (ack !== 5'b00010) begin n_err++; $display("FAIL hold_release_ack: got %b, required 00010", ack); end
    next_cycle();
    out_ready = 1'b0;
    @(negedge clk);
    n_vec++; if (sel !== 5'b00100) begin n_err++; $display("FAIL hold_next_sel: got %b, required 00100", sel); end
    req = '0;
    check_drained("hold");
  endtask

  task automatic test_wrap();
    do_reset();
    req = 5'b01000;
    out_ready = 1'b1;
    exp_q.push_back(5'b01000);
    next_cycle();
    @(negedge clk);
    n_vec++; if (sel !== 5'b01000) begin n_err++; $display("FAIL wrap_setup_sel: got %b, required 01000", sel); end
    next_cycle();
    req = 5'b00011;
    exp_q.push_back(5'b00001);
    exp_q.push_back(5'b00010);
    @(negedge clk);
    n_vec++; if (dut.ptr_q !== 3'd4) begin n_err++; $display("FAIL wrap_ptr: got %0d, required 4", dut.ptr_q); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL wrap_idle: got %b, required 0", out_valid); end
    next_cycle();
    @(negedge clk);
    n_vec++; if (sel !== 5'b00001) begin n_err++; $display("FAIL wrap_sel: got %b, required 00001", sel); end
    next_cycle();
    req = 5'b00010;
    @(negedge clk);
    n_vec++; if (sel !== 5'b00010) begin n_err++; $display("FAIL wrap_next_sel: got %b, required 00010", sel); end
    next_cycle();
    req = '0;
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL wrap_end_valid: got %b, required 0", out_valid); end
    check_drained("wrap");
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 5'b00010;
    out_ready = 1'b1;
    exp_q.push_back(5'b00010);
    next_cycle();
    next_cycle();
    req = 5'b01000;
    out_ready = 1'b0;
    next_cycle();
    @(negedge clk);
    n_vec++; if (sel !== 5'b01000) begin n_err++; $display("FAIL rstmid_sel: got %b, required 01000", sel); end
    next_cycle();
    rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (ack !== 5'b00000) begin n_err++; $display("FAIL rstmid_ack: got %b, required 00000", ack); end
    next_cycle();
    rst = 1'b0;
    req = 5'b11111;
    out_ready = 1'b0;
    @(negedge clk);
    n_vec++; if (sel !== 5'b00000) begin n_err++; $display("FAIL rstmid_cleared_sel: got %b, required 00000", sel); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_cleared_valid: got %b, required 0", out_valid); end
    next_cycle();
    @(negedge clk);
    n_vec++; if (sel !== 5'b00001) begin n_err++; $display("FAIL rstmid_restart_sel: got %b, required 00001", sel); end
    req = '0;
    check_drained("rstmid");
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    req = 5'b00011;
    out_ready = 1'b1;
    lock = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back(5'b00001);
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_vec++; if (sel !== 5'b00001) begin n_err++; $display("FAIL lock_sel%0d: got %b, required 00001", k, sel); end
      next_cycle();
    end
    lock = 1'b0;
    @(negedge clk);
    n_vec++; if (dut.ptr_q !== 3'd0) begin n_err++; $display("FAIL lock_ptr: got %0d, required 0", dut.ptr_q); end
    n_vec++; if (sel !== 5'b00001) begin n_err++; $display("FAIL lock_sel3: got %b, required 00001", sel); end
    next_cycle();
    out_ready = 1'b0;
    @(negedge clk);
    n_vec++; if (sel !== 5'b00010) begin n_err++; $display("FAIL lock_release_sel: got %b, required 00010", sel); end
    req = '0;
    check_drained("lock");
  endtask
`endif

  task automatic test_random();
    logic [NR-1:0] pending;
    logic [NR-1:0] m_sel;
    logic [NR-1:0] rem;
    int            m_ptr;
    int            gi;
    bit            xfer;
    do_reset();
    pending = '0;
    m_sel = '0;
    m_ptr = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      for (int i = 0; i < NR; i++) begin
        if (pending[i] && !m_sel[i] && $urandom_range(0, 7) == 0) pending[i] = 1'b0;
        else if (!pending[i] && $urandom_range(0, 2) == 0) pending[i] = 1'b1;
      end
      req = pending;
      out_ready = 1'($urandom_range(0, 1));
      xfer = (m_sel != '0) && out_ready;
      if (xfer) exp_q.push_back(m_sel);
      @(negedge clk);
      n_vec++; if (sel !== m_sel) begin n_err++; $display("FAIL rand_sel c%0d: got %b, required %b", cyc, sel, m_sel); end
      n_vec++; if (out_valid !== (m_sel != '0)) begin n_err++; $display("FAIL rand_valid c%0d: got %b, required %b", cyc, out_valid, (m_sel != '0)); end
      if (m_sel == '0) begin
        if (pending != '0) m_sel = rr_model(pending, m_ptr);
      end else if (xfer) begin
        gi = 0;
        for (int i = 0; i < NR; i++) if (m_sel[i]) gi = i;
        m_ptr = (gi + 1) % NR;
        rem = pending & ~m_sel;
        pending = rem;
        m_sel = (rem != '0) ? rr_model(rem, m_ptr) : '0;
      end
      next_cycle();
    end
    req = '0;
    out_ready = 1'b0;
    check_drained("rand");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hold();
    test_wrap();
    test_reset_mid_grant();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    repeat (2) next_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
